spio_spinnaker_link_pkt_deserializer: RTL and testbench

Receive-side counterpart of the link sender. It samples the 7 asynchronous NRZ 2-of-7 SpiNNaker link wires, detects and decodes flits, and returns the transition-signalled acknowledge. It reassembles the nibbles into 40-bit short or 72-bit long packets and presents them on a synchronous valid/ready packet interface. It sits between the off-chip SpiNNaker link pins and the packet router/FIFO in the CLK_IN domain.

---
 rtl/spio_spinnaker_link_pkt_deserializer_pkg.sv | 16 +
 rtl/spio_spinnaker_link_2of7_decoder.sv | 47 ++++
 rtl/spio_spinnaker_link_pkt_deserializer.sv | 186 ++++++++++++++++++
 tb/tb_spio_spinnaker_link_pkt_deserializer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/spio_spinnaker_link_pkt_deserializer_pkg.sv
// Shared constants and types for the SpiNNaker link packet deserializer.
package spio_spinnaker_link_pkt_deserializer_pkg;

  localparam int unsigned PKT_BITS         = 72;
  localparam logic [6:0]  SL_EOP_2OF7      = 7'b1100000;
  localparam logic [4:0]  SL_SHORT_NIBBLES = 5'd10;
  localparam logic [4:0]  SL_LONG_NIBBLES  = 5'd18;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StStall,
    StDrop
  } rx_state_e;

endpackage

// File: rtl/spio_spinnaker_link_2of7_decoder.sv
// Combinational 2-of-7 flit decoder operating on the wire-transition vector.
module spio_spinnaker_link_2of7_decoder
  import spio_spinnaker_link_pkt_deserializer_pkg::*;
(
  input  logic [6:0] diff,
  output logic [3:0] value,
  output logic       is_eop,
  output logic       is_err,
  output logic       flit_present
);

  int unsigned ones;

  // Classify the transition pattern into data nibble, EOP or error.
  always_comb begin
    ones         = $countones(diff);
    flit_present = (ones >= 2);
    value        = 4'h0;
    is_eop       = 1'b0;
    is_err       = 1'b0;
    if (ones > 2) begin
      is_err = 1'b1;
    end else if (ones == 2) begin
      case (diff)
        7'b0010001: value = 4'h0;
        7'b0010010: value = 4'h1;
        7'b0010100: value = 4'h2;
        7'b0011000: value = 4'h3;
        7'b0100001: value = 4'h4;
        7'b0100010: value = 4'h5;
        7'b0100100: value = 4'h6;
        7'b0101000: value = 4'h7;
        7'b1000001: value = 4'h8;
        7'b1000010: value = 4'h9;
        7'b1000100: value = 4'hA;
        7'b1001000: value = 4'hB;
        7'b0000011: value = 4'hC;
        7'b0000110: value = 4'hD;
        7'b0001100: value = 4'hE;
        7'b0001001: value = 4'hF;
        SL_EOP_2OF7: is_eop = 1'b1;
        default:     is_err = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/spio_spinnaker_link_pkt_deserializer.sv
// SpiNNaker link receiver: synchronises 2-of-7 NRZ wires, decodes flits,
// returns the NRZ ack and assembles short/long packets onto valid/ready.
// Optional error counter port enabled by `define SPIO_SL_RX_ERR_CNT_EN.
module spio_spinnaker_link_pkt_deserializer
  import spio_spinnaker_link_pkt_deserializer_pkg::*;
(
  input  logic                CLK_IN,
  input  logic                RESET_IN,
  input  logic [6:0]          SL_DATA_2OF7_IN,
  output logic                SL_ACK_OUT,
  output logic [PKT_BITS-1:0] PKT_DATA_OUT,
  output logic                PKT_VLD_OUT,
  input  logic                PKT_RDY_IN
`ifdef SPIO_SL_RX_ERR_CNT_EN
  ,
  output logic [15:0]         ERR_CNT_OUT
`endif
);

  logic [6:0]          s1_q, sync_q, old_q, old_d;
  logic                ack_q, ack_d;
  rx_state_e           state_q, state_d;
  logic [4:0]          nib_q, nib_d;
  logic [PKT_BITS-1:0] buf_q, buf_d;
  logic                long_q, long_d;
  logic [PKT_BITS-1:0] data_q, data_d;
  logic                vld_q, vld_d;
  logic                err_inc;

  logic [3:0] value;
  logic       is_eop, is_err, flit_present;
  logic       is_data, len_ok, can_load;

  spio_spinnaker_link_2of7_decoder u_decoder (
    .diff         (sync_q ^ old_q),
    .value        (value),
    .is_eop       (is_eop),
    .is_err       (is_err),
    .flit_present (flit_present)
  );

  assign is_data  = flit_present && !is_eop && !is_err;
  assign len_ok   = long_q ? (nib_q == SL_LONG_NIBBLES) : (nib_q == SL_SHORT_NIBBLES);
  assign can_load = !vld_q || PKT_RDY_IN;

  // Receive FSM, flit consumption and output register next state.
  always_comb begin
    state_d = state_q;
    nib_d   = nib_q;
    buf_d   = buf_q;
    long_d  = long_q;
    old_d   = old_q;
    ack_d   = ack_q;
    data_d  = data_q;
    vld_d   = vld_q;
    err_inc = 1'b0;

    if (vld_q && PKT_RDY_IN) vld_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (flit_present) begin
          old_d = sync_q;
          ack_d = ~ack_q;
          if (is_eop) begin
            err_inc = 1'b1;
          end else if (is_err) begin
            err_inc = 1'b1;
            state_d = StDrop;
          end else begin
            buf_d   = {{(PKT_BITS-4){1'b0}}, value};
            long_d  = value[1];
            nib_d   = 5'd1;
            state_d = StRecv;
          end
        end
      end
      StRecv: begin
        if (is_err || (is_data && nib_q == SL_LONG_NIBBLES)) begin
          old_d   = sync_q;
          ack_d   = ~ack_q;
          err_inc = 1'b1;
          state_d = StDrop;
        end else if (is_data) begin
          old_d = sync_q;
          ack_d = ~ack_q;
          buf_d[{nib_q, 2'b00} +: 4] = value;
          nib_d = nib_q + 5'd1;
        end else if (is_eop) begin
          if (!len_ok) begin
            old_d   = sync_q;
            ack_d   = ~ack_q;
            err_inc = 1'b1;
            state_d = StIdle;
          end else if (can_load) begin
            // Load directly so a free-running consumer never stalls the link.
            old_d   = sync_q;
            ack_d   = ~ack_q;
            data_d  = long_q ? buf_q : {32'h0, buf_q[39:0]};
            vld_d   = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StStall;
          end
        end
      end
      StStall: begin
        // EOP stays unconsumed (ack withheld) until the output slot frees.
        if (can_load) begin
          old_d   = sync_q;
          ack_d   = ~ack_q;
          data_d  = long_q ? buf_q : {32'h0, buf_q[39:0]};
          vld_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StDrop: begin
        if (flit_present) begin
          old_d = sync_q;
          ack_d = ~ack_q;
          if (is_eop) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StIdle) begin
      nib_d  = 5'd0;
      buf_d  = '0;
      long_d = 1'b0;
    end
  end

  // State, synchroniser and output registers.
  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      s1_q    <= '0;
      sync_q  <= '0;
      old_q   <= '0;
      ack_q   <= 1'b0;
      state_q <= StIdle;
      nib_q   <= '0;
      buf_q   <= '0;
      long_q  <= 1'b0;
      data_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      s1_q    <= SL_DATA_2OF7_IN;
      sync_q  <= s1_q;
      old_q   <= old_d;
      ack_q   <= ack_d;
      state_q <= state_d;
      nib_q   <= nib_d;
      buf_q   <= buf_d;
      long_q  <= long_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
    end
  end

  assign SL_ACK_OUT   = ack_q;
  assign PKT_DATA_OUT = data_q;
  assign PKT_VLD_OUT  = vld_q;

`ifdef SPIO_SL_RX_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Saturating count of dropped packets and framing errors.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_inc && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
  end

  // Error counter register.
  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) err_cnt_q <= '0;
    else          err_cnt_q <= err_cnt_d;
  end

  assign ERR_CNT_OUT = err_cnt_q;
`else
  logic unused_err_inc;
  assign unused_err_inc = err_inc;
`endif

endmodule

// File: tb/tb_spio_spinnaker_link_pkt_deserializer.sv
// Directed bench for the SpiNNaker link packet deserializer.
module tb_spio_spinnaker_link_pkt_deserializer;

  logic        CLK_IN = 1'b0;
  logic        RESET_IN;
  logic [6:0]  SL_DATA_2OF7_IN;
  logic        SL_ACK_OUT;
  logic [71:0] PKT_DATA_OUT;
  logic        PKT_VLD_OUT;
  logic        PKT_RDY_IN;
`ifdef SPIO_SL_RX_ERR_CNT_EN
  logic [15:0] ERR_CNT_OUT;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int ack_toggles = 0;
  logic [6:0] wires = 7'h0;

  localparam logic [6:0] EOP = 7'b1100000;

  spio_spinnaker_link_pkt_deserializer dut (
    .CLK_IN          (CLK_IN),
    .RESET_IN        (RESET_IN),
    .SL_DATA_2OF7_IN (SL_DATA_2OF7_IN),
    .SL_ACK_OUT      (SL_ACK_OUT),
    .PKT_DATA_OUT    (PKT_DATA_OUT),
    .PKT_VLD_OUT     (PKT_VLD_OUT),
    .PKT_RDY_IN      (PKT_RDY_IN)
`ifdef SPIO_SL_RX_ERR_CNT_EN
    ,
    .ERR_CNT_OUT     (ERR_CNT_OUT)
`endif
  );

  always #5 CLK_IN = ~CLK_IN;

  always @(SL_ACK_OUT) ack_toggles++;

  function automatic logic [6:0] enc(input logic [3:0] v);
    case (v)
      4'h0: enc = 7'b0010001;  4'h1: enc = 7'b0010010;
      4'h2: enc = 7'b0010100;  4'h3: enc = 7'b0011000;
      4'h4: enc = 7'b0100001;  4'h5: enc = 7'b0100010;
      4'h6: enc = 7'b0100100;  4'h7: enc = 7'b0101000;
      4'h8: enc = 7'b1000001;  4'h9: enc = 7'b1000010;
      4'hA: enc = 7'b1000100;  4'hB: enc = 7'b1001000;
      4'hC: enc = 7'b0000011;  4'hD: enc = 7'b0000110;
      4'hE: enc = 7'b0001100;  default: enc = 7'b0001001;
    endcase
  endfunction

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Toggle the wires for one symbol and wait (bounded) for the ack toggle.
  task automatic send(input logic [6:0] code, input bit chk_lat);
    logic a0;
    int   n;
    a0 = SL_ACK_OUT;
    wires = wires ^ code;
    SL_DATA_2OF7_IN = wires;
    n = 0;
    while (SL_ACK_OUT === a0 && n < 20) begin
      @(posedge CLK_IN); #1; n++;
    end
    check("ack_toggled", {71'h0, SL_ACK_OUT}, {71'h0, ~a0});
    if (chk_lat) check("ack_latency", 72'(n), 72'd3);
  endtask

  task automatic send_nibs(input logic [71:0] d, input int n, input bit chk_lat);
    for (int i = 0; i < n; i++) send(enc(d[4*i +: 4]), chk_lat);
  endtask

  initial begin
    logic a0;
    RESET_IN = 1'b1;
    PKT_RDY_IN = 1'b0;
    SL_DATA_2OF7_IN = 7'h0;
    repeat (3) @(posedge CLK_IN);
    #1;
    check("rst_ack", {71'h0, SL_ACK_OUT}, 72'h0);
    check("rst_vld", {71'h0, PKT_VLD_OUT}, 72'h0);
    check("rst_data", PKT_DATA_OUT, 72'h0);
`ifdef SPIO_SL_RX_ERR_CNT_EN
    check("rst_err", {56'h0, ERR_CNT_OUT}, 72'h0);
`endif
    RESET_IN = 1'b0;
    @(posedge CLK_IN); #1;

    // Short packet.
    ack_toggles = 0;
    send_nibs(72'h12_3456_7800, 10, 1'b0);
    send(EOP, 1'b0);
    check("short_data", PKT_DATA_OUT, 72'h00_0000_0012_3456_7800);
    check("short_vld", {71'h0, PKT_VLD_OUT}, 72'h1);
    check("short_acks", 72'(ack_toggles), 72'd11);
    PKT_RDY_IN = 1'b1;
    @(posedge CLK_IN); #1;
    check("short_drain", {71'h0, PKT_VLD_OUT}, 72'h0);
    PKT_RDY_IN = 1'b0;

    // Long packet with per-flit latency check.
    send_nibs(72'hDEAD_BEEF_CAFE_F00D_02, 18, 1'b1);
    send(EOP, 1'b1);
    check("long_data", PKT_DATA_OUT, 72'hDEAD_BEEF_CAFE_F00D_02);
    check("long_vld", {71'h0, PKT_VLD_OUT}, 72'h1);

    // Back-pressure: second packet's EOP held until the first drains.
    send_nibs(72'h98_7654_3210, 10, 1'b0);
    a0 = SL_ACK_OUT;
    wires = wires ^ EOP;
    SL_DATA_2OF7_IN = wires;
    repeat (10) @(posedge CLK_IN);
    #1;
    check("bp_ack_held", {71'h0, SL_ACK_OUT}, {71'h0, a0});
    check("bp_data_held", PKT_DATA_OUT, 72'hDEAD_BEEF_CAFE_F00D_02);
    PKT_RDY_IN = 1'b1;
    @(posedge CLK_IN); #1;
    check("bp_ack_release", {71'h0, SL_ACK_OUT}, {71'h0, ~a0});
    check("bp_vld_kept", {71'h0, PKT_VLD_OUT}, 72'h1);
    check("bp_data_new", PKT_DATA_OUT, 72'h00_0000_0098_7654_3210);
    @(posedge CLK_IN); #1;
    check("bp_drain", {71'h0, PKT_VLD_OUT}, 72'h0);
    PKT_RDY_IN = 1'b0;

    // Invalid code {2,0} at nibble 3.
    send_nibs(72'h000, 3, 1'b0);
    send(7'b0000101, 1'b0);
    send_nibs(72'h0, 6, 1'b0);
    send(EOP, 1'b0);
    repeat (2) @(posedge CLK_IN); #1;
    check("inv_vld", {71'h0, PKT_VLD_OUT}, 72'h0);
`ifdef SPIO_SL_RX_ERR_CNT_EN
    check("inv_err", {56'h0, ERR_CNT_OUT}, 72'd1);
`endif

    // Length error: short header, 12 nibbles.
    send_nibs(72'h0, 12, 1'b0);
    send(EOP, 1'b0);
    repeat (2) @(posedge CLK_IN); #1;
    check("len_vld", {71'h0, PKT_VLD_OUT}, 72'h0);
`ifdef SPIO_SL_RX_ERR_CNT_EN
    check("len_err", {56'h0, ERR_CNT_OUT}, 72'd2);
`endif
    send_nibs(72'h11_2233_4450, 10, 1'b0);
    send(EOP, 1'b0);
    check("len_next_data", PKT_DATA_OUT, 72'h00_0000_0011_2233_4450);
    check("len_next_vld", {71'h0, PKT_VLD_OUT}, 72'h1);
    PKT_RDY_IN = 1'b1;
    @(posedge CLK_IN); #1;
    PKT_RDY_IN = 1'b0;

    // Overlong: long header with a 19th nibble.
    send_nibs(72'hF_0000_0000_0000_0000_2, 19, 1'b0);
    send(EOP, 1'b0);
    repeat (2) @(posedge CLK_IN); #1;
    check("ovl_vld", {71'h0, PKT_VLD_OUT}, 72'h0);

    // Three-hot symbol in IDLE is an error flit.
    send(7'b0000111, 1'b0);
    send(EOP, 1'b0);
    repeat (2) @(posedge CLK_IN); #1;
    check("hot3_vld", {71'h0, PKT_VLD_OUT}, 72'h0);
`ifdef SPIO_SL_RX_ERR_CNT_EN
    check("hot3_err", {56'h0, ERR_CNT_OUT}, 72'd4);
`endif

    // Reset mid-packet after nibble 5.
    send_nibs(72'hAB_CDE1, 5, 1'b0);
    RESET_IN = 1'b1;
    #1;
    check("mid_rst_ack", {71'h0, SL_ACK_OUT}, 72'h0);
    check("mid_rst_vld", {71'h0, PKT_VLD_OUT}, 72'h0);
    wires = 7'h0;
    SL_DATA_2OF7_IN = wires;
    repeat (3) @(posedge CLK_IN);
    #1;
    RESET_IN = 1'b0;
    @(posedge CLK_IN); #1;
    send_nibs(72'h0F_EDCB_A981, 10, 1'b0);
    send(EOP, 1'b0);
    check("post_rst_data", PKT_DATA_OUT, 72'h00_0000_000F_EDCB_A981);
    check("post_rst_vld", {71'h0, PKT_VLD_OUT}, 72'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
